// File: rtl/cpu_types_pkg.sv
// Shared types for the single-core memory subsystem.
// RAM handshake states, arbiter FSM states and the machine word.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2,
      DLOCK  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/arb_lock_ctr.sv
// Block-lock window counter for the memory arbiter.
// Ports: CLK, nRST, load (arm window), dec (one lock cycle spent),
// expired (last lock cycle reached).
module arb_lock_ctr #(
   parameter int LOCK_CYCLES = 4
) (
   input  logic CLK,
   input  logic nRST,
   input  logic load,
   input  logic dec,
   output logic expired
);

   localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   logic [CW-1:0] cnt;

   // Loaded with LOCK_CYCLES-1 on entry to the lock; zero means the
   // current lock cycle is the last one allowed.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         cnt <= '0;
      else if (load)
         cnt <= CW'(LOCK_CYCLES - 1);
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: icache/dcache word requests onto one RAM port,
// dcache priority, grant held between the two beats of a dcache block.
// Ports: CLK, nRST; icache iREN/iaddr/iwait/iload; dcache
// dREN/dWEN/daddr/dstore/dwait/dload; RAM ramREN/ramWEN/ramaddr/
// ramstore/ramload/ramstate.
// Option MEM_ARBITER_STATS_EN adds dcount, icount, stallcount.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int LOCK_CYCLES = 4,
   parameter int RAM_ADDR_W  = 32
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  iREN,
   input  logic [RAM_ADDR_W-1:0] iaddr,
   output logic                  iwait,
   output word_t                 iload,
   input  logic                  dREN,
   input  logic                  dWEN,
   input  logic [RAM_ADDR_W-1:0] daddr,
   input  word_t                 dstore,
   output logic                  dwait,
   output word_t                 dload,
   output logic                  ramREN,
   output logic                  ramWEN,
   output logic [RAM_ADDR_W-1:0] ramaddr,
   output word_t                 ramstore,
   input  word_t                 ramload,
   input  logic [1:0]            ramstate
`ifdef MEM_ARBITER_STATS_EN
  ,output logic [31:0]           dcount,
   output logic [31:0]           icount,
   output logic [31:0]           stallcount
`endif
);

   arb_state_t state;
   ramstate_t  rs;
   logic       d_req;
   logic       acc;
   logic       lk_load;
   logic       lk_dec;
   logic       lk_exp;

   assign rs    = ramstate_t'(ramstate);
   assign acc   = (rs == ACCESS);
   assign d_req = dREN | dWEN;

   // Arm the lock only when beat 0 (word bit 2 clear) completes.
   assign lk_load = (state == DGRANT) && d_req && acc && !daddr[2];
   assign lk_dec  = (state == DLOCK);

   arb_lock_ctr #(
      .LOCK_CYCLES(LOCK_CYCLES)
   ) u_lock (
      .CLK     (CLK),
      .nRST    (nRST),
      .load    (lk_load),
      .dec     (lk_dec),
      .expired (lk_exp)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (d_req)
                  state <= DGRANT;
               else if (iREN)
                  state <= IGRANT;
            end
            DGRANT: begin
               if (!d_req)
                  state <= IDLE;
               else if (acc)
                  state <= daddr[2] ? IDLE : DLOCK;
            end
            IGRANT: begin
               if (!iREN || acc)
                  state <= IDLE;
            end
            DLOCK: begin
               if (d_req && daddr[2])
                  state <= DGRANT;
               else if (!d_req || lk_exp)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes are decoded from the registered grant; the handshake
   // side follows ramstate in the same cycle. A dropped request
   // drops its strobe and never completes.
   always_comb begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      unique case (1'b1)
         (state == DGRANT): begin
            ramaddr = daddr;
            if (dWEN) begin
               ramWEN   = 1'b1;
               ramstore = dstore;
            end else begin
               ramREN = dREN;
            end
            if (d_req && acc) begin
               dwait = 1'b0;
               dload = ramload;
            end
         end
         (state == IGRANT): begin
            ramaddr = iaddr;
            ramREN  = iREN;
            if (iREN && acc) begin
               iwait = 1'b0;
               iload = ramload;
            end
         end
         default: ;
      endcase
   end

`ifdef MEM_ARBITER_STATS_EN
   logic stall;

   assign stall = iREN && iwait &&
                  (state == DGRANT || state == DLOCK);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         dcount     <= '0;
         icount     <= '0;
         stallcount <= '0;
      end else begin
         if (!dwait && dcount != '1)
            dcount <= dcount + 1'b1;
         if (!iwait && icount != '1)
            icount <= icount + 1'b1;
         if (stall && stallcount != '1)
            stallcount <= stallcount + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Scenario tasks run in sequence; one summary line at the end.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic        CLK;
   logic        nRST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
`ifdef MEM_ARBITER_STATS_EN
   logic [31:0] dcount;
   logic [31:0] icount;
   logic [31:0] stallcount;
`endif

   int checks;
   int errors;
   int dpulses;
   int ipulses;
   bit iseen;

   mem_arbiter dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate)
`ifdef MEM_ARBITER_STATS_EN
     ,.dcount     (dcount),
      .icount     (icount),
      .stallcount (stallcount)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (nRST && !dwait) dpulses++;
      if (nRST && !iwait) ipulses++;
      if (ramREN && ramaddr == 32'h40) iseen = 1'b1;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      iREN     = 1'b0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      iaddr    = '0;
      daddr    = '0;
      dstore   = '0;
      ramstate = BUSY;
   endtask

   task automatic settle();
      idle_inputs();
      tick(); tick(); tick();
      dpulses = 0;
      ipulses = 0;
      iseen   = 1'b0;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      idle_inputs();
      ramload = 32'hAAAA5555;
      tick(); tick();
      checks++;
      if (iwait !== 1'b1 || dwait !== 1'b1) begin
         errors++;
         $display("FAIL reset_waits: iwait=%b dwait=%b want 1/1",
                  iwait, dwait);
      end
      checks++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobes: ren=%b wen=%b want 0/0",
                  ramREN, ramWEN);
      end
      checks++;
      if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin
         errors++;
         $display("FAIL reset_addr: addr=%h store=%h want 0",
                  ramaddr, ramstore);
      end
      checks++;
      if (iload !== 32'h0 || dload !== 32'h0) begin
         errors++;
         $display("FAIL reset_loads: iload=%h dload=%h want 0",
                  iload, dload);
      end
      nRST = 1'b1;
      settle();
   endtask

   task automatic test_contention();
      int n;
      iREN    = 1'b1;
      iaddr   = 32'h40;
      dREN    = 1'b1;
      daddr   = 32'h100;
      ramload = 32'h11112222;
      tick();
      checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin
         errors++;
         $display("FAIL cont_dfirst: ren=%b addr=%h want 1/100",
                  ramREN, ramaddr);
      end
      tick();
      ramstate = ACCESS;
      #1;
      checks++;
      if (dwait !== 1'b0 || dload !== 32'h11112222 || iwait !== 1'b1)
      begin
         errors++;
         $display("FAIL cont_dload: dwait=%b dload=%h iwait=%b",
                  dwait, dload, iwait);
      end
      tick();
      dREN     = 1'b0;
      ramstate = BUSY;
      ramload  = 32'h33334444;
      n = 0;
      while (!(ramREN && ramaddr == 32'h40) && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 10) begin
         errors++;
         $display("FAIL cont_igrant: timeout waiting icache grant");
      end
      ramstate = ACCESS;
      #1;
      checks++;
      if (iwait !== 1'b0 || iload !== 32'h33334444) begin
         errors++;
         $display("FAIL cont_iload: iwait=%b iload=%h want 0/33334444",
                  iwait, iload);
      end
      tick();
      iREN = 1'b0;
      tick();
      checks++;
      if (dpulses !== 1 || ipulses !== 1) begin
         errors++;
         $display("FAIL cont_pulses: d=%0d i=%0d want 1/1",
                  dpulses, ipulses);
      end
      settle();
   endtask

   task automatic test_block_lock();
      int n;
      ramstate = ACCESS;
      ramload  = 32'h0BADF00D;
      iREN     = 1'b1;
      iaddr    = 32'h40;
      dREN     = 1'b1;
      daddr    = 32'h200;
      tick();
      checks++;
      if (dwait !== 1'b0 || ramaddr !== 32'h200) begin
         errors++;
         $display("FAIL lock_beat0: dwait=%b addr=%h want 0/200",
                  dwait, ramaddr);
      end
      tick();
      checks++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 1'b1) begin
         errors++;
         $display("FAIL lock_quiet: ren=%b wen=%b iwait=%b",
                  ramREN, ramWEN, iwait);
      end
      daddr = 32'h204;
      tick();
      checks++;
      if (dwait !== 1'b0 || ramaddr !== 32'h204 || ramREN !== 1'b1) begin
         errors++;
         $display("FAIL lock_beat1: dwait=%b addr=%h ren=%b",
                  dwait, ramaddr, ramREN);
      end
      checks++;
      if (iseen !== 1'b0) begin
         errors++;
         $display("FAIL lock_split: icache granted inside block");
      end
      dREN = 1'b0;
      n = 0;
      while (!(ramREN && ramaddr == 32'h40) && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 10 || iwait !== 1'b0) begin
         errors++;
         $display("FAIL lock_after: n=%0d iwait=%b want grant",
                  n, iwait);
      end
      iREN = 1'b0;
      settle();
   endtask

   task automatic test_lock_expiry();
      int n;
      ramstate = ACCESS;
      iREN     = 1'b1;
      iaddr    = 32'h40;
      dREN     = 1'b1;
      daddr    = 32'h200;
      tick();
      tick();
      dREN = 1'b0;
      tick();
      checks++;
      if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin
         errors++;
         $display("FAIL exp_idle: ren=%b addr=%h want 0/0",
                  ramREN, ramaddr);
      end
      tick();
      checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b0) begin
         errors++;
         $display("FAIL exp_igrant: ren=%b addr=%h iwait=%b",
                  ramREN, ramaddr, iwait);
      end
      iREN = 1'b0;
      settle();
      // Beat 0 held with no beat 1: lock lasts 4 cycles, then IDLE,
      // then the dcache is granted again.
      ramstate = ACCESS;
      dREN     = 1'b1;
      daddr    = 32'h208;
      tick();
      n = 0;
      tick();
      while (!ramREN && n < 20) begin
         n++;
         tick();
      end
      checks++;
      if (n !== 5) begin
         errors++;
         $display("FAIL exp_window: gap=%0d want 5", n);
      end
      dREN = 1'b0;
      settle();
   endtask

   task automatic test_write_prec();
      ramstate = BUSY;
      dREN     = 1'b1;
      dWEN     = 1'b1;
      daddr    = 32'h10;
      dstore   = 32'hDEADBEEF;
      tick();
      checks++;
      if (ramWEN !== 1'b1 || ramREN !== 1'b0 ||
          ramstore !== 32'hDEADBEEF || ramaddr !== 32'h10) begin
         errors++;
         $display("FAIL wr_strobe: wen=%b ren=%b st=%h addr=%h",
                  ramWEN, ramREN, ramstore, ramaddr);
      end
      tick();
      ramstate = ACCESS;
      #1;
      checks++;
      if (dwait !== 1'b0) begin
         errors++;
         $display("FAIL wr_done: dwait=%b want 0", dwait);
      end
      tick();
      dREN = 1'b0;
      dWEN = 1'b0;
      tick(); tick();
      checks++;
      if (dpulses !== 1) begin
         errors++;
         $display("FAIL wr_pulses: got %0d want 1", dpulses);
      end
      settle();
   endtask

   task automatic test_withdraw();
      ramstate = BUSY;
      iREN     = 1'b1;
      iaddr    = 32'h80;
      tick();
      checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin
         errors++;
         $display("FAIL wd_grant: ren=%b addr=%h want 1/80",
                  ramREN, ramaddr);
      end
      iREN = 1'b0;
      tick();
      checks++;
      if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin
         errors++;
         $display("FAIL wd_idle: ren=%b addr=%h want 0/0",
                  ramREN, ramaddr);
      end
      ramstate = ACCESS;
      tick(); tick();
      checks++;
      if (ipulses !== 0) begin
         errors++;
         $display("FAIL wd_pulse: got %0d want 0", ipulses);
      end
      settle();
   endtask

   task automatic test_error();
      int bad;
      bad      = 0;
      ramstate = ERROR;
      ramload  = 32'hCAFEF00D;
      iREN     = 1'b1;
      iaddr    = 32'h84;
      tick();
      for (int k = 0; k < 3; k++) begin
         if (ramREN !== 1'b1 || ramaddr !== 32'h84 || iwait !== 1'b1)
            bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL err_hold: %0d unstable cycles want 0", bad);
      end
      ramstate = ACCESS;
      #1;
      checks++;
      if (iwait !== 1'b0 || iload !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL err_done: iwait=%b iload=%h", iwait, iload);
      end
      tick();
      iREN = 1'b0;
      tick(); tick();
      checks++;
      if (ipulses !== 1) begin
         errors++;
         $display("FAIL err_pulses: got %0d want 1", ipulses);
      end
      settle();
   endtask

   task automatic test_reset_mid();
      ramstate = BUSY;
      dREN     = 1'b1;
      daddr    = 32'h300;
      tick();
      checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin
         errors++;
         $display("FAIL rstmid_pre: ren=%b addr=%h want 1/300",
                  ramREN, ramaddr);
      end
      #1;
      nRST = 1'b0;
      #1;
      checks++;
      if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dwait !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_drop: ren=%b addr=%h dwait=%b",
                  ramREN, ramaddr, dwait);
      end
      dREN = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      settle();
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      dpulses = 0;
      ipulses = 0;
      iseen   = 1'b0;
      nRST    = 1'b0;
      ramload = '0;
      idle_inputs();
      test_reset();
      test_contention();
      test_block_lock();
      test_lock_expiry();
      test_write_prec();
      test_withdraw();
      test_error();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
